clause_bank: RTL and testbench
==============================

CLAUSE_BANK -- requirements
Module: clause_bank

Interface
REQ-001 Parameter NUM_VARS_A_BIN, default 8, variables per bin.
REQ-002 Parameter NUM_CLAUSES, default 8, clause slots in the bank (power of two, minimum 2).
REQ-003 Derived localparam CIDX_W = $clog2(NUM_CLAUSES); VIDX_W = $clog2(NUM_VARS_A_BIN).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 wr_i  input  1  load clause_lits_i into slot wr_addr_i.
REQ-007 wr_addr_i  input  CIDX_W  slot address for load.
REQ-008 clause_lits_i  input  NUM_VARS_A_BIN*2  per var 2 bits: 00 absent, 01 negative literal, 10 positive literal, 11 treated as absent.
REQ-009 var_value_i  input  NUM_VARS_A_BIN*2  per var 2 bits: 00 free, 01 false, 10 true, 11 treated as free.
REQ-010 start_i  input  1  begin a scan of all slots.
REQ-011 apply_backtrack_i  input  1  abort scan, clear results.
REQ-012 busy_o  output  1  scan in progress.
REQ-013 done_o  output  1  one-cycle scan-complete pulse.
REQ-014 conflict_o / conflict_idx_o  output  1 / CIDX_W  conflict found, lowest conflicting slot.
REQ-015 imp_valid_o / imp_var_o / imp_value_o / imp_idx_o  output  1 / VIDX_W / 1 / CIDX_W  first unit implication: variable, implied value, reason slot.
REQ-016 sat_count_o  output  CIDX_W+1  number of satisfied valid slots in last scan.

Function
REQ-017 Each slot stores lits plus a valid bit; load sets valid=1 unless all lits absent, which sets valid=0.
REQ-018 wr_i is accepted only in IDLE; ignored while busy_o=1.
REQ-019 FSM states IDLE, SCAN, DONE; IDLE->SCAN on start_i; SCAN->DONE after last slot or on conflict; DONE->IDLE unconditionally after one cycle.
REQ-020 On entering SCAN all result outputs clear to 0; busy_o=1 throughout SCAN.
REQ-021 SCAN evaluates one slot per cycle in ascending index from 0, sampling var_value_i in that cycle.
REQ-022 Slot satisfied: valid and any literal true (positive with value 10, negative with value 01).
REQ-023 Slot unit: valid, not satisfied, exactly one free literal; implied var = that literal's index, value = 1 if positive else 0.
REQ-024 Slot conflicting: valid, not satisfied, zero free literals.
REQ-025 First unit slot latches imp_*; later units do not overwrite.
REQ-026 Conflict latches conflict_o=1, conflict_idx_o, terminates scan the following cycle (no further slots evaluated); imp_* retained.
REQ-027 done_o=1 in DONE only; latency start_i to done_o = NUM_CLAUSES+1 cycles without conflict, k+2 cycles with conflict at slot k.
REQ-028 start_i outside IDLE ignored; results hold stable from DONE until next start or backtrack.
REQ-029 apply_backtrack_i in any state: next cycle FSM=IDLE, all result outputs 0, no done_o pulse; wins over simultaneous start_i; slot contents retained.
REQ-030 Invalid slots count as neither satisfied, unit nor conflicting.

Reset
REQ-031 rst=0 asynchronously forces FSM=IDLE, all valid bits 0, all outputs 0.
REQ-032 Reset mid-scan discards the scan; no done_o after release.

Configuration
REQ-033 Macro CLAUSE_BANK_SATCNT_EN defined: sat_count_o counts satisfied slots up to scan end (partial count on conflict).
REQ-034 Macro undefined: counter logic omitted, sat_count_o tied 0; all other behaviour identical.

Verification (NUM_VARS_A_BIN=8, NUM_CLAUSES=4)
REQ-035 Load slot0 {v1 neg, v3 pos, v5 pos}, values v3=true, start -> done_o at cycle 5, conflict_o=0, imp_valid_o=0, sat_count_o=1 (macro on).
REQ-036 Same slot0, values v1=true, v5=false, v3 free -> imp_valid_o=1, imp_var_o=3, imp_value_o=1, imp_idx_o=0.
REQ-037 Slot0 unit as above, slot2 {v0 pos} with v0=false -> conflict_o=1, conflict_idx_o=2, imp_idx_o=0, done_o at cycle 4.
REQ-038 apply_backtrack_i asserted same cycle as start_i, then mid-scan -> busy_o=0 next cycle, no done_o, all results 0.
REQ-039 rst pulled low during SCAN, then slot0 empty-loaded; rescan -> no implications/conflicts, sat_count_o=0, wr_i during busy has no effect.

Source files
------------

// File: rtl/clause_bank_if.sv
// Bus bundle for clause_bank: clause load port, scan control and scan results.
// The slave modport is the bank side; the master modport is the driver side.
interface clause_bank_if #(
    parameter int NUM_VARS_A_BIN = 8,
    parameter int NUM_CLAUSES    = 8
);
    localparam int CIDX_W = $clog2(NUM_CLAUSES);
    localparam int VIDX_W = $clog2(NUM_VARS_A_BIN);

    logic                        wr_i;
    logic [CIDX_W-1:0]           wr_addr_i;
    logic [NUM_VARS_A_BIN*2-1:0] clause_lits_i;
    logic [NUM_VARS_A_BIN*2-1:0] var_value_i;
    logic                        start_i;
    logic                        apply_backtrack_i;

    logic                        busy_o;
    logic                        done_o;
    logic                        conflict_o;
    logic [CIDX_W-1:0]           conflict_idx_o;
    logic                        imp_valid_o;
    logic [VIDX_W-1:0]           imp_var_o;
    logic                        imp_value_o;
    logic [CIDX_W-1:0]           imp_idx_o;
    logic [CIDX_W:0]             sat_count_o;

    modport master (
        output wr_i, wr_addr_i, clause_lits_i, var_value_i, start_i, apply_backtrack_i,
        input  busy_o, done_o, conflict_o, conflict_idx_o, imp_valid_o, imp_var_o,
               imp_value_o, imp_idx_o, sat_count_o
    );

    modport slave (
        input  wr_i, wr_addr_i, clause_lits_i, var_value_i, start_i, apply_backtrack_i,
        output busy_o, done_o, conflict_o, conflict_idx_o, imp_valid_o, imp_var_o,
               imp_value_o, imp_idx_o, sat_count_o
    );
endinterface

// File: rtl/clause_bank.sv
// Clause bank: stores clauses and scans them one slot per cycle for unit/conflict.
// Define CLAUSE_BANK_SATCNT_EN to build the satisfied-slot counter behind sat_count_o.
module clause_bank #(
    parameter int NUM_VARS_A_BIN = 8,
    parameter int NUM_CLAUSES    = 8
) (
    input  logic         clk,
    input  logic         rst,
    clause_bank_if.slave bus
);
    localparam int CIDX_W = $clog2(NUM_CLAUSES);
    localparam int VIDX_W = $clog2(NUM_VARS_A_BIN);
    localparam int LITS_W = NUM_VARS_A_BIN * 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [VIDX_W:0]   FREE_ONE  = 1;
    localparam logic [CIDX_W-1:0] LAST_SLOT = CIDX_W'(NUM_CLAUSES - 1);

    logic [1:0]             state;
    logic [CIDX_W-1:0]      ptr;
    logic [LITS_W-1:0]      lits_mem [NUM_CLAUSES];
    logic [NUM_CLAUSES-1:0] slot_valid;

    logic                   conflict_q;
    logic [CIDX_W-1:0]      conflict_idx_q;
    logic                   imp_valid_q;
    logic [VIDX_W-1:0]      imp_var_q;
    logic                   imp_value_q;
    logic [CIDX_W-1:0]      imp_idx_q;

    logic                   write_en;
    logic                   load_valid;
    logic                   start_scan;
    logic [LITS_W-1:0]      cur_lits;
    logic                   any_true;
    logic [VIDX_W:0]        free_cnt;
    logic [VIDX_W-1:0]      free_var;
    logic                   free_pos;
    logic                   slot_sat;
    logic                   slot_unit;
    logic                   slot_conf;

    assign write_en   = bus.wr_i && (state == ST_IDLE);
    assign start_scan = bus.start_i && (state == ST_IDLE) && !bus.apply_backtrack_i;

    // A clause with no 01/10 literal pair carries no constraint and is stored as invalid.
    always_comb begin
        load_valid = 1'b0;
        for (int v = 0; v < NUM_VARS_A_BIN; v++) begin
            if (bus.clause_lits_i[2*v +: 2] == 2'b01 || bus.clause_lits_i[2*v +: 2] == 2'b10)
                load_valid = 1'b1;
        end
    end

    // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        cur_lits = lits_mem[ptr];
        any_true = 1'b0;
        free_cnt = '0;
        free_var = '0;
        free_pos = 1'b0;
        for (int v = 0; v < NUM_VARS_A_BIN; v++) begin
            logic lit_pos, lit_neg, val_true, val_false;
            lit_pos   = (cur_lits[2*v +: 2] == 2'b10);
            lit_neg   = (cur_lits[2*v +: 2] == 2'b01);
            val_true  = (bus.var_value_i[2*v +: 2] == 2'b10);
            val_false = (bus.var_value_i[2*v +: 2] == 2'b01);
            if ((lit_pos && val_true) || (lit_neg && val_false))
                any_true = 1'b1;
            if ((lit_pos || lit_neg) && !val_true && !val_false) begin
                free_cnt = free_cnt + FREE_ONE;
                free_var = VIDX_W'(v);
                free_pos = lit_pos;
            end
        end
        slot_sat  = slot_valid[ptr] && any_true;
        slot_unit = slot_valid[ptr] && !any_true && (free_cnt == FREE_ONE);
        slot_conf = slot_valid[ptr] && !any_true && (free_cnt == '0);
    end

    // NOTE: clause storage has no reset; the reset-cleared valid bits make stale contents unobservable.
    always_ff @(posedge clk) begin
        if (write_en)
            lits_mem[bus.wr_addr_i] <= bus.clause_lits_i;
    end

    // NOTE: sequential state always uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            slot_valid <= '0;
        else if (write_en)
            slot_valid[bus.wr_addr_i] <= load_valid;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            ptr            <= '0;
            conflict_q     <= 1'b0;
            conflict_idx_q <= '0;
            imp_valid_q    <= 1'b0;
            imp_var_q      <= '0;
            imp_value_q    <= 1'b0;
            imp_idx_q      <= '0;
        end else if (bus.apply_backtrack_i || start_scan) begin
            state          <= bus.apply_backtrack_i ? ST_IDLE : ST_SCAN;
            ptr            <= '0;
            conflict_q     <= 1'b0;
            conflict_idx_q <= '0;
            imp_valid_q    <= 1'b0;
            imp_var_q      <= '0;
            imp_value_q    <= 1'b0;
            imp_idx_q      <= '0;
        end else begin
            case (state)
                ST_SCAN: begin
                    if (slot_conf) begin
                        conflict_q     <= 1'b1;
                        conflict_idx_q <= ptr;
                        state          <= ST_DONE;
                    end else begin
                        // Only the first unit slot of a scan supplies the implication.
                        if (slot_unit && !imp_valid_q) begin
                            imp_valid_q <= 1'b1;
                            imp_var_q   <= free_var;
                            imp_value_q <= free_pos;
                            imp_idx_q   <= ptr;
                        end
                        if (ptr == LAST_SLOT)
                            state <= ST_DONE;
                        else
                            ptr <= ptr + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef CLAUSE_BANK_SATCNT_EN
    logic [CIDX_W:0] sat_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sat_count_q <= '0;
        else if (bus.apply_backtrack_i || start_scan)
            sat_count_q <= '0;
        else if (state == ST_SCAN && slot_sat)
            sat_count_q <= sat_count_q + 1'b1;
    end

    assign bus.sat_count_o = sat_count_q;
`else
    assign bus.sat_count_o = '0;
`endif

    assign bus.busy_o         = (state == ST_SCAN);
    assign bus.done_o         = (state == ST_DONE);
    assign bus.conflict_o     = conflict_q;
    assign bus.conflict_idx_o = conflict_idx_q;
    assign bus.imp_valid_o    = imp_valid_q;
    assign bus.imp_var_o      = imp_var_q;
    assign bus.imp_value_o    = imp_value_q;
    assign bus.imp_idx_o      = imp_idx_q;
endmodule

// File: tb/tb_clause_bank.sv
// Self-checking bench for clause_bank: directed scenarios plus randomized scans
// compared against a slot-by-slot reference model of the clause rules.
module tb_clause_bank;
    localparam int NV = 8;
    localparam int NC = 4;

    typedef struct {
        int conflict;
        int cidx;
        int iv;
        int ivar;
        int ival;
        int iidx;
        int sat;
        int lat;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [2*NV-1:0] m_lits [NC];
    bit              m_valid [NC];

    clause_bank_if #(.NUM_VARS_A_BIN(NV), .NUM_CLAUSES(NC)) bus ();

    clause_bank #(.NUM_VARS_A_BIN(NV), .NUM_CLAUSES(NC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: walk the slots in order, applying the literal/value rules directly.
    function automatic res_t model_scan(input logic [2*NV-1:0] vals);
        res_t r;
        r = '{default: 0};
        r.lat = NC + 1;
        for (int s = 0; s < NC; s++) begin
            int nfree = 0;
            int fvar  = 0;
            int fpos  = 0;
            bit sat   = 0;
            if (!m_valid[s]) continue;
            for (int v = 0; v < NV; v++) begin
                logic [1:0] lit, val;
                lit = m_lits[s][2*v +: 2];
                val = vals[2*v +: 2];
                if (lit != 2'b01 && lit != 2'b10) continue;
                if ((lit == 2'b10 && val == 2'b10) || (lit == 2'b01 && val == 2'b01))
                    sat = 1;
                else if (val == 2'b00 || val == 2'b11) begin
                    nfree++;
                    fvar = v;
                    fpos = (lit == 2'b10);
                end
            end
            if (sat) begin
`ifdef CLAUSE_BANK_SATCNT_EN
                r.sat++;
`endif
            end else if (nfree == 1) begin
                if (r.iv == 0) begin
                    r.iv   = 1;
                    r.ivar = fvar;
                    r.ival = fpos;
                    r.iidx = s;
                end
            end else if (nfree == 0) begin
                r.conflict = 1;
                r.cidx     = s;
                r.lat      = s + 2;
                break;
            end
        end
        return r;
    endfunction

    function automatic bit lits_valid(input logic [2*NV-1:0] lits);
        for (int v = 0; v < NV; v++)
            if (lits[2*v +: 2] == 2'b01 || lits[2*v +: 2] == 2'b10) return 1;
        return 0;
    endfunction

    task automatic load(input int slot, input logic [2*NV-1:0] lits);
        bus.wr_i          = 1'b1;
        bus.wr_addr_i     = 2'(slot);
        bus.clause_lits_i = lits;
        @(negedge clk);
        bus.wr_i = 1'b0;
        m_lits[slot]  = lits;
        m_valid[slot] = lits_valid(lits);
    endtask

    task automatic check_results(input string tag, input res_t e);
        check({tag, "_conflict"},     bus.conflict_o,     e.conflict);
        check({tag, "_conflict_idx"}, bus.conflict_idx_o, e.cidx);
        check({tag, "_imp_valid"},    bus.imp_valid_o,    e.iv);
        check({tag, "_imp_var"},      bus.imp_var_o,      e.ivar);
        check({tag, "_imp_value"},    bus.imp_value_o,    e.ival);
        check({tag, "_imp_idx"},      bus.imp_idx_o,      e.iidx);
        check({tag, "_sat_count"},    bus.sat_count_o,    e.sat);
    endtask

    // Starts a scan, measures start-to-done latency and checks results in DONE and one cycle later.
    task automatic run_scan(input string tag, input logic [2*NV-1:0] vals, input bit inj_wr,
                            output int lat);
        res_t e;
        e = model_scan(vals);
        bus.var_value_i = vals;
        bus.start_i     = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        if (inj_wr) begin
            bus.wr_i          = 1'b1;
            bus.wr_addr_i     = 2'd1;
            bus.clause_lits_i = 16'h0002;
        end
        check({tag, "_busy"}, bus.busy_o, 1);
        lat = 1;
        while (!bus.done_o && lat < 40) begin
            @(negedge clk);
            bus.wr_i = 1'b0;
            lat++;
        end
        bus.wr_i = 1'b0;
        check({tag, "_latency"}, lat, e.lat);
        check_results(tag, e);
        @(negedge clk);
        check({tag, "_done_pulse"}, bus.done_o, 0);
        check({tag, "_idle"}, bus.busy_o, 0);
        check_results({tag, "_hold"}, e);
    endtask

    initial begin
        int   lat;
        int   saw_done;
        res_t zero;
        zero = '{default: 0};

        bus.wr_i = 0; bus.wr_addr_i = 0; bus.clause_lits_i = 0; bus.var_value_i = 0;
        bus.start_i = 0; bus.apply_backtrack_i = 0;
        for (int s = 0; s < NC; s++) begin
            m_lits[s]  = '0;
            m_valid[s] = 0;
        end
        repeat (2) @(negedge clk);
        check("reset_busy", bus.busy_o, 0);
        check("reset_done", bus.done_o, 0);
        check_results("reset", zero);
        rst = 1'b1;
        @(negedge clk);

        // Satisfied slot0: v1 neg, v3 pos, v5 pos with v3 true.
        load(0, 16'h0884);
        run_scan("sat", 16'h0080, 0, lat);
        check("sat_lat_const", lat, 5);
`ifdef CLAUSE_BANK_SATCNT_EN
        check("sat_count_const", bus.sat_count_o, 1);
`endif

        // Unit slot0: v1 true, v5 false, v3 free -> implies v3 = 1.
        run_scan("unit", 16'h0408, 0, lat);
        check("unit_imp_var_const", bus.imp_var_o, 3);

        // Conflict at slot2 {v0 pos} with v0 false; implication from slot0 retained.
        load(2, 16'h0002);
        run_scan("conf", 16'h0409, 0, lat);
        check("conf_lat_const", lat, 4);
        check("conf_idx_const", bus.conflict_idx_o, 2);

        // Backtrack coincident with start wins.
        bus.start_i = 1'b1;
        bus.apply_backtrack_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.apply_backtrack_i = 1'b0;
        check("bt_start_busy", bus.busy_o, 0);
        check("bt_start_done", bus.done_o, 0);

        // Backtrack mid-scan after an implication has been latched.
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        @(negedge clk);
        check("bt_mid_imp_before", bus.imp_valid_o, 1);
        bus.apply_backtrack_i = 1'b1;
        @(negedge clk);
        bus.apply_backtrack_i = 1'b0;
        check("bt_mid_busy", bus.busy_o, 0);
        check("bt_mid_done", bus.done_o, 0);
        check_results("bt_mid", zero);
        saw_done = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done_o) saw_done = 1;
        end
        check("bt_mid_no_done", saw_done, 0);

        // Asynchronous reset mid-scan discards the scan and all valid bits.
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_busy", bus.busy_o, 0);
        check_results("rst_mid", zero);
        for (int s = 0; s < NC; s++) m_valid[s] = 0;
        @(negedge clk);
        rst = 1'b1;
        saw_done = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done_o) saw_done = 1;
        end
        check("rst_mid_no_done", saw_done, 0);

        // Empty-loaded slot0; a write while busy must not land in slot1.
        load(0, 16'h0000);
        run_scan("empty", 16'h0001, 1, lat);
        run_scan("wr_busy_ignored", 16'h0001, 0, lat);
        check("wr_busy_no_conflict", bus.conflict_o, 0);

        // Randomized clause sets and assignments.
        for (int it = 0; it < 40; it++) begin
            for (int s = 0; s < NC; s++) begin
                if ($urandom_range(0, 1) == 0) begin
                    logic [2*NV-1:0] lits;
                    lits = '0;
                    for (int v = 0; v < NV; v++) begin
                        case ($urandom_range(0, 7))
                            0: lits[2*v +: 2] = 2'b01;
                            1: lits[2*v +: 2] = 2'b10;
                            2: lits[2*v +: 2] = 2'b11;
                            default: lits[2*v +: 2] = 2'b00;
                        endcase
                    end
                    load(s, lits);
                end
            end
            run_scan($sformatf("rand%0d", it), 16'($urandom), 0, lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
